// File: rtl/dmac_pkg.sv
// Shared types and defaults for the scaled bipolar stochastic MAC datapath.
package dmac_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACC  = 2'd2,
    DONE = 2'd3
  } state_t;

  localparam int N_IN_DEF     = 16;
  localparam int WIN_LOG2_DEF = 8;
  localparam int OUT_W_DEF    = 8;

  // Accumulator width: window length times the widest per-cycle popcount.
  function automatic int acc_w(input int n_in, input int win_log2);
    return win_log2 + $clog2(n_in + 1);
  endfunction

endpackage

// File: rtl/dmac_popcount.sv
// Combinational ones counter over N_IN bits, built as a recursive binary adder tree.
module dmac_popcount #(
  parameter int N_IN  = 16,
  parameter int CNT_W = $clog2(N_IN + 1)
) (
  input  logic [N_IN-1:0]  bits,
  output logic [CNT_W-1:0] count
);

  generate
    if (N_IN == 1) begin : g_leaf
      assign count = bits;
    end else begin : g_split
      localparam int HALF = N_IN / 2;
      localparam int HW   = $clog2(HALF + 1);

      logic [HW-1:0] cnt_lo;
      logic [HW-1:0] cnt_hi;

      dmac_popcount #(.N_IN(HALF)) u_lo (
        .bits  (bits[HALF-1:0]),
        .count (cnt_lo)
      );

      dmac_popcount #(.N_IN(HALF)) u_hi (
        .bits  (bits[N_IN-1:HALF]),
        .count (cnt_hi)
      );

      assign count = CNT_W'(cnt_lo) + CNT_W'(cnt_hi);
    end
  endgenerate

endmodule

// File: rtl/dmac_bi_scaled_acc.sv
// Window sequencer and popcount accumulator behind the bipolar multiplier array;
// emits the raw ones count and its saturated, scaled bipolar code per Sobol period.
//
// state | meaning
// IDLE  | waiting for start
// LOAD  | one-cycle operand load strobe, accumulator/counter cleared
// ACC   | Sobol advancing, popcount accumulated for 2^WIN_LOG2 cycles
// DONE  | result registered, oValid pulse; start here chains the next window
module dmac_bi_scaled_acc
  import dmac_pkg::*;
#(
  parameter int N_IN     = N_IN_DEF,
  parameter int WIN_LOG2 = WIN_LOG2_DEF,
  parameter int OUT_W    = OUT_W_DEF,
  localparam int ACC_W   = acc_w(N_IN, WIN_LOG2)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [N_IN-1:0]  iProd,
  output logic             load,
  output logic             seqEn,
  output logic             busy,
  output logic             oValid,
  output logic [ACC_W-1:0] oSum,
  output logic [OUT_W-1:0] oC
);

  localparam int CNT_W = $clog2(N_IN + 1);
  localparam int SHIFT = $clog2(N_IN);
  localparam logic [ACC_W-1:0] OC_MAX = ACC_W'((1 << OUT_W) - 1);

  state_t              state;
  logic [CNT_W-1:0]    pop;
  logic [ACC_W-1:0]    acc;
  logic [ACC_W-1:0]    acc_next;
  logic [ACC_W-1:0]    scaled;
  logic [OUT_W-1:0]    oc_next;
  logic [WIN_LOG2-1:0] cnt;

  dmac_popcount #(.N_IN(N_IN)) u_popcount (
    .bits  (iProd),
    .count (pop)
  );

  // The last ACC cycle's bits are folded into the result directly, not via acc.
  assign acc_next = acc + ACC_W'(pop);
  assign scaled   = acc_next >> SHIFT;
  assign oc_next  = (scaled > OC_MAX) ? OC_MAX[OUT_W-1:0] : scaled[OUT_W-1:0];

  always_ff @(posedge clk) begin
    if (rst) begin
      state  <= IDLE;
      acc    <= '0;
      cnt    <= '0;
      load   <= 1'b0;
      seqEn  <= 1'b0;
      busy   <= 1'b0;
      oValid <= 1'b0;
      oSum   <= '0;
      oC     <= '0;
    end else begin
      load   <= 1'b0;
      oValid <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end
        end
        LOAD: begin
          state <= ACC;
          acc   <= '0;
          cnt   <= '0;
          seqEn <= 1'b1;
        end
        ACC: begin
          acc <= acc_next;
          cnt <= cnt + 1'b1;
          if (cnt == '1) begin
            state  <= DONE;
            seqEn  <= 1'b0;
            busy   <= 1'b0;
            oValid <= 1'b1;
            oSum   <= acc_next;
            oC     <= oc_next;
          end
        end
        DONE: begin
          if (start) begin
            state <= LOAD;
            load  <= 1'b1;
            busy  <= 1'b1;
          end else begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dmac_bi_scaled_acc.sv
// Directed bench for dmac_bi_scaled_acc: window results, sequencing strobes,
// start during ACC, mid-window reset and back-to-back windows.
module tb_dmac_bi_scaled_acc;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] iProd;
  logic        load;
  logic        seqEn;
  logic        busy;
  logic        oValid;
  logic [12:0] oSum;
  logic [7:0]  oC;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  dmac_bi_scaled_acc dut (
    .clk    (clk),
    .rst    (rst),
    .start  (start),
    .iProd  (iProd),
    .load   (load),
    .seqEn  (seqEn),
    .busy   (busy),
    .oValid (oValid),
    .oSum   (oSum),
    .oC     (oC)
  );

  task automatic check_val(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Starts one window from IDLE (cycle 1 = LOAD), observes 260 cycles at negedge.
  // poke > 0 pulses start for one cycle at that observed cycle.
  task automatic run_window(input string tag, input logic [15:0] prod, input int poke,
                            input int exp_sum, input int exp_oc);
    int n_load = 0, n_seq = 0, n_busy = 0, n_valid = 0, first_valid = 0;
    int sum_at = -1, oc_at = -1;
    iProd = prod;
    start = 1'b1;
    for (int c = 1; c <= 260; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
      if (load)   n_load++;
      if (seqEn)  n_seq++;
      if (busy)   n_busy++;
      if (oValid) begin
        n_valid++;
        if (first_valid == 0) begin
          first_valid = c;
          sum_at = int'(oSum);
          oc_at  = int'(oC);
        end
      end
      if (poke > 0 && c == poke)     start = 1'b1;
      if (poke > 0 && c == poke + 1) start = 1'b0;
    end
    check_val({tag, "_latency"}, first_valid, 258);
    check_val({tag, "_sum"}, sum_at, exp_sum);
    check_val({tag, "_oc"}, oc_at, exp_oc);
    check_val({tag, "_n_valid"}, n_valid, 1);
    check_val({tag, "_n_load"}, n_load, 1);
    check_val({tag, "_n_seqen"}, n_seq, 256);
    check_val({tag, "_n_busy"}, n_busy, 257);
    check_val({tag, "_sum_held"}, int'(oSum), exp_sum);
    check_val({tag, "_oc_held"}, int'(oC), exp_oc);
  endtask

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    iProd = 16'h0000;
    repeat (3) @(negedge clk);
    check_val("rst_outputs", {load, seqEn, busy, oValid}, 0);
    check_val("rst_sum", int'(oSum), 0);
    check_val("rst_oc", int'(oC), 0);
    rst = 1'b0;
    @(negedge clk);

    run_window("all_ones", 16'hFFFF, 0, 4096, 255);
    run_window("all_zero", 16'h0000, 0, 0, 0);
    run_window("half", 16'h00FF, 0, 2048, 128);
    // ACC cycle 50 is observed cycle 51
    run_window("start_in_acc", 16'h00FF, 51, 2048, 128);

    // Mid-window reset at ACC cycle 100
    iProd = 16'hFFFF;
    start = 1'b1;
    for (int c = 1; c <= 101; c++) begin
      @(negedge clk);
      if (c == 1) start = 1'b0;
    end
    check_val("pre_rst_seqen", int'(seqEn), 1);
    rst = 1'b1;
    @(negedge clk);
    check_val("midrst_flags", {load, seqEn, busy, oValid}, 0);
    check_val("midrst_sum", int'(oSum), 0);
    check_val("midrst_oc", int'(oC), 0);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_val("midrst_idle_busy", int'(busy), 0);
    run_window("after_rst", 16'h000F, 0, 1024, 64);

    // start held high: windows chain with a 258-cycle period and no carry-over
    begin
      int pulses = 0;
      int last = 0;
      iProd = 16'hFFFF;
      start = 1'b1;
      for (int c = 1; c <= 780; c++) begin
        @(negedge clk);
        if (oValid) begin
          pulses++;
          check_val("b2b_period", c - last, 258);
          check_val("b2b_sum", int'(oSum), 4096);
          check_val("b2b_oc", int'(oC), 255);
          last = c;
        end
      end
      start = 1'b0;
      check_val("b2b_pulses", pulses, 3);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/dmac_bi_scaled_acc.md
# dmac_bi_scaled_acc

Downstream stage of the bipolar stochastic multiplier array in the scaled 16-input MAC. Each cycle it takes the 16 product bits emitted by the bipolar multipliers and adds them in parallel with a popcount. It accumulates the count over one full Sobol period of 2^WIN_LOG2 cycles, then converts the result to a binary, scaled, bipolar-coded value. It also sequences the window: it pulses the multipliers' operand-load strobe and gates the shared Sobol generator.

## Interface
- N_IN, 16, number of product bitstreams summed per cycle; must be a power of two.
- WIN_LOG2, 8, log2 of accumulation window length in cycles; matches the Sobol sequence width.
- OUT_W, 8, width of scaled binary output.
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset; synchronous, active-high.
- start  in  1  request a new window; sampled only in IDLE or DONE.
- iProd  in  N_IN  product bits from the multiplier array, one per multiplier.
- load  out  1  one-cycle strobe to the multipliers' loadA/loadB.
- seqEn  out  1  advance enable for the shared Sobol generators; high exactly during ACC.
- busy  out  1  high in LOAD and ACC.
- oValid  out  1  one-cycle pulse; oSum and oC are valid while high and held afterwards.
- oSum  out  ACC_W  raw ones count over the window; ACC_W = WIN_LOG2 + clog2(N_IN+1), which is 13 at the defaults.
- oC  out  OUT_W  scaled result, computed as min(oSum >> log2(N_IN), 2^OUT_W − 1).

## Operation
- The FSM has four states: IDLE, LOAD, ACC and DONE.
  - IDLE: start=1 goes to LOAD. Otherwise stay in IDLE.
  - LOAD: load=1 for exactly one cycle. The accumulator and window counter clear to 0. Always goes to ACC.
  - ACC: seqEn=1. Each cycle the accumulator adds popcount(iProd) and the counter increments. When the counter equals 2^WIN_LOG2 − 1, that cycle's bits are still added and the FSM goes to DONE.
  - DONE: the final sum is registered into oSum and oC, and oValid=1 for this one cycle. start=1 goes to LOAD (back-to-back windows). Otherwise go to IDLE.
- start is ignored in LOAD and ACC; no queueing.
- The window holds exactly 2^WIN_LOG2 summed cycles. No product bit is dropped or double-counted.
- Arithmetic:
  - The popcount is 0..N_IN, on clog2(N_IN+1) bits.
  - The accumulator cannot overflow; its maximum is N_IN·2^WIN_LOG2 = 4096 at the defaults.
  - oC saturates only at full scale: 4096 >> 4 = 256 clips to 255.
- Bipolar meaning: oC/2^(OUT_W−1) − 1 approximates the mean of the N_IN bipolar products. This is the scaled-add result.
- Reset, including mid-window:
  - The FSM returns to IDLE and the accumulator and counter clear.
  - oSum=0, oC=0, oValid=0, load=0, seqEn=0, busy=0.
- iProd is consumed only in ACC; its value in other states has no effect.

## Timing
- Reset values: every output is 0.
- start is sampled at edge T in IDLE. LOAD is then active in cycle T+1, with load high during it.
- The multiplier buffers capture on the edge that ends LOAD. The first valid iProd appears in the first ACC cycle, which is combinational from those buffers and the Sobol value.
- ACC lasts exactly 2^WIN_LOG2 cycles (256 at the defaults).
- oValid asserts in the cycle after the last ACC cycle.
- Start-to-oValid latency is 2^WIN_LOG2 + 2 cycles, i.e. 258.
- Back-to-back windows: a period of 2^WIN_LOG2 + 2 cycles, with start held or re-asserted in DONE.
- oSum and oC are registered. They hold until the next DONE or reset.

## Structure
- Shared package dmac_pkg holds:
  - the state enum: IDLE, LOAD, ACC, DONE;
  - the constants N_IN_DEF, WIN_LOG2_DEF, OUT_W_DEF;
  - an ACC_W function (WIN_LOG2 + clog2(N_IN+1)).
- One sub-module, dmac_popcount: a parameterised N_IN-input ones counter, purely combinational, built as an adder tree.
- The FSM, window counter, accumulator and output scaling live in the top module.

## Test plan
- iProd=16'hFFFF for the whole window, then start → after 258 cycles oValid=1, oSum=4096, oC=255 (saturated).
- iProd=16'h0000 for the whole window → oSum=0, oC=0.
- iProd=16'h00FF every cycle (8 ones) → oSum=2048, oC=128 (bipolar zero).
- start pulsed again during ACC cycle 50 → ignored. Exactly one oValid at cycle 258, with seqEn high for exactly 256 cycles and load high for exactly one.
- rst asserted at ACC cycle 100 with iProd=16'hFFFF → next cycle all outputs 0 and FSM in IDLE. A subsequent window with 16'h000F gives oSum=1024, oC=64.
- start held high continuously with iProd=16'hFFFF → oValid pulses every 258 cycles, oSum=4096 each window. The accumulator clears between windows, so there is no carry-over.
